gfp8_group_accumulator: RTL and testbench



---
 rtl/gfp8_acc_pkg.sv | 33 +++
 rtl/gfp8_group_accumulator_if.sv | 34 +++
 rtl/gfp8_align_shift.sv | 21 ++
 rtl/gfp8_group_accumulator.sv | 122 ++++++++++++
 tb/tb_gfp8_group_accumulator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gfp8_acc_pkg.sv
// rtl/gfp8_acc_pkg.sv - shared types, default widths and clamp helper for the GFP8 group accumulator
package gfp8_acc_pkg;

  localparam int DOT_W_DEF = 24;
  localparam int ACC_W_DEF = 32;
  localparam int EXP_W_DEF = 5;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  // Exact sum of two sign-extended operands, clamped to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/gfp8_group_accumulator_if.sv
// rtl/gfp8_group_accumulator_if.sv - beat input and result output bundle for the GFP8 group accumulator
interface gfp8_group_accumulator_if
  import gfp8_acc_pkg::*;
#(
  parameter int DOT_W = DOT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic                    i_valid;
  logic                    o_ready;
  logic signed [DOT_W-1:0] i_dot;
  logic [EXP_W-1:0]        i_exp_a;
  logic [EXP_W-1:0]        i_exp_b;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [ACC_W-1:0] o_mant;
  logic [EXP_W:0]          o_exp;
  logic [CNT_W-1:0]        o_count;
  logic                    o_sat;

  modport master (
    output i_valid, i_dot, i_exp_a, i_exp_b, i_last, i_ready,
    input  o_ready, o_valid, o_mant, o_exp, o_count, o_sat
  );

  modport slave (
    input  i_valid, i_dot, i_exp_a, i_exp_b, i_last, i_ready,
    output o_ready, o_valid, o_mant, o_exp, o_count, o_sat
  );

endinterface

// File: rtl/gfp8_align_shift.sv
// rtl/gfp8_align_shift.sv - arithmetic right shift that floors and fills with sign bits for oversize shifts
module gfp8_align_shift
  import gfp8_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SH_W  = EXP_W_DEF + 1
) (
  input  logic signed [ACC_W-1:0] din,
  input  logic [SH_W-1:0]         shamt,
  output logic signed [ACC_W-1:0] dout
);

  always_comb begin
    if (int'(shamt) >= ACC_W) begin
      dout = {ACC_W{din[ACC_W-1]}};
    end else begin
      dout = din >>> shamt;
    end
  end

endmodule

// File: rtl/gfp8_group_accumulator.sv
// rtl/gfp8_group_accumulator.sv - aligns group dot products to a running block exponent and accumulates per element
// Define GFP8_ACC_SATURATE_EN to clamp overflowing sums and report a sticky o_sat; otherwise sums wrap.
module gfp8_group_accumulator
  import gfp8_acc_pkg::*;
#(
  parameter int DOT_W = DOT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                      i_clk,
  input logic                      i_reset_n,
  gfp8_group_accumulator_if.slave  bus
);

  localparam int SH_W = EXP_W + 1;

  state_t                  state;
  state_t                  state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] dot_ext;
  logic signed [ACC_W-1:0] shift_in;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_sum;
  logic [SH_W-1:0]         acc_exp;
  logic [SH_W-1:0]         beat_exp;
  logic [SH_W-1:0]         shamt;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;
  logic                    ovf;
  logic                    exp_gt;
  logic                    ready;
  logic                    accept;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    ready      = (state != OUT);
    accept     = bus.i_valid && ready;
    state_next = state;
    case (state)
      IDLE, ACCUM: if (accept) state_next = bus.i_last ? OUT : ACCUM;
      OUT:         if (bus.i_ready) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Only the operand with the smaller exponent is shifted down to the larger one.
  always_comb begin
    beat_exp = SH_W'(bus.i_exp_a) + SH_W'(bus.i_exp_b);
    dot_ext  = ACC_W'(bus.i_dot);
    exp_gt   = beat_exp > acc_exp;
    shift_in = exp_gt ? acc : dot_ext;
    addend   = exp_gt ? dot_ext : acc;
    shamt    = exp_gt ? (beat_exp - acc_exp) : (acc_exp - beat_exp);
  end

  gfp8_align_shift #(
    .ACC_W (ACC_W),
    .SH_W  (SH_W)
  ) u_align (
    .din   (shift_in),
    .shamt (shamt),
    .dout  (shifted)
  );

`ifdef GFP8_ACC_SATURATE_EN
  logic signed [63:0] sum_wide;
  logic signed [63:0] sum_clamped;

  always_comb begin
    sum_wide    = 64'(shifted) + 64'(addend);
    sum_clamped = sat_add(64'(shifted), 64'(addend), ACC_W);
    ovf         = (sum_clamped != sum_wide);
    acc_sum     = ACC_W'(sum_clamped);
  end
`else
  always_comb begin
    acc_sum = shifted + addend;
    ovf     = 1'b0;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc     <= '0;
      acc_exp <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc     <= dot_ext;
        acc_exp <= beat_exp;
        cnt     <= CNT_W'(1);
        sat     <= 1'b0;
      end else begin
        acc <= acc_sum;
        if (exp_gt) acc_exp <= beat_exp;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
        sat <= sat | ovf;
      end
    end else if ((state == OUT) && bus.i_ready) begin
      sat <= 1'b0;
    end
  end

  // Result registers are the accumulator itself; nothing can be accepted while in OUT, so they hold.
  assign bus.o_ready = ready;
  assign bus.o_valid = (state == OUT);
  assign bus.o_mant  = acc;
  assign bus.o_exp   = acc_exp;
  assign bus.o_count = cnt;
  assign bus.o_sat   = sat;

endmodule

// File: tb/tb_gfp8_group_accumulator.sv
// tb/tb_gfp8_group_accumulator.sv - self-checking bench for gfp8_group_accumulator
module tb_gfp8_group_accumulator;

  localparam int DOT_W = 24;
  localparam int ACC_W = 25;
  localparam int EXP_W = 5;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gfp8_group_accumulator_if #(
    .DOT_W(DOT_W), .ACC_W(ACC_W), .EXP_W(EXP_W), .CNT_W(CNT_W)
  ) bus ();

  gfp8_group_accumulator #(
    .DOT_W(DOT_W), .ACC_W(ACC_W), .EXP_W(EXP_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  longint m_acc;
  int     m_exp;
  int     m_cnt;
  bit     m_sat;
  bit     m_first = 1'b1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint shr(input longint v, input int k);
    if (k >= ACC_W) return (v < 0) ? -64'sd1 : 64'sd0;
    return v >>> k;
  endfunction

  function automatic longint fit(input longint v, output bit ov);
    longint hi;
    longint lo;
    longint modulus;
    hi      = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo      = -hi - 1;
    modulus = longint'(1) <<< ACC_W;
    ov      = (v > hi) || (v < lo);
`ifdef GFP8_ACC_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    while (v > hi) v -= modulus;
    while (v < lo) v += modulus;
    return v;
`endif
  endfunction

  task automatic model_beat(input longint dot, input int e);
    longint s;
    bit     ov;
    if (m_first) begin
      m_acc   = dot;
      m_exp   = e;
      m_cnt   = 1;
      m_sat   = 1'b0;
      m_first = 1'b0;
    end else begin
      if (e > m_exp) begin
        s     = shr(m_acc, e - m_exp) + dot;
        m_exp = e;
      end else begin
        s = m_acc + shr(dot, m_exp - e);
      end
      m_acc = fit(s, ov);
`ifdef GFP8_ACC_SATURATE_EN
      m_sat = m_sat | ov;
`endif
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  task automatic drive_beat(input longint dot, input int ea, input int eb, input bit last);
    bit got;
    got         = 1'b0;
    bus.i_dot   = DOT_W'(dot);
    bus.i_exp_a = EXP_W'(ea);
    bus.i_exp_b = EXP_W'(eb);
    bus.i_last  = last;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    model_beat(dot, ea + eb);
  endtask

  task automatic check_result(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, bus.o_valid, 1);
    check({tag, "_mant"},  bus.o_mant,  m_acc);
    check({tag, "_exp"},   bus.o_exp,   m_exp);
    check({tag, "_count"}, bus.o_count, m_cnt);
    check({tag, "_sat"},   bus.o_sat,   m_sat);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    m_first     = 1'b1;
  endtask

  initial begin
    logic signed [DOT_W-1:0] rdot;
    int len;
    bus.i_valid = 1'b0;
    bus.i_dot   = '0;
    bus.i_exp_a = '0;
    bus.i_exp_b = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_mant",  bus.o_mant,  0);
    check("rst_exp",   bus.o_exp,   0);
    check("rst_count", bus.o_count, 0);
    check("rst_sat",   bus.o_sat,   0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive_beat(100, 3, 4, 1);
    check("single_mant_const", bus.o_mant, 100);
    check_result("single");

    drive_beat(10, 10, 10, 0);
    drive_beat(-3, 10, 10, 0);
    drive_beat(5, 10, 10, 1);
    check("equal_mant_const", bus.o_mant, 12);
    check_result("equal");

    drive_beat(64, 5, 5, 0);
    drive_beat(1, 6, 6, 1);
    check("align_up_const", bus.o_mant, 17);
    check_result("align_up");

    drive_beat(-1, 6, 6, 0);
    drive_beat(7, 5, 5, 1);
    check("align_down_const", bus.o_mant, 0);
    check_result("align_down");

    drive_beat(-5, 0, 0, 0);
    drive_beat(3, 31, 31, 1);
    check("big_shift_const", bus.o_mant, 2);
    check_result("big_shift");

    // Result held under backpressure while the next beat waits upstream.
    drive_beat(-300, 7, 8, 1);
    bus.i_dot   = DOT_W'(55);
    bus.i_exp_a = EXP_W'(2);
    bus.i_exp_b = EXP_W'(3);
    bus.i_last  = 1'b1;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", bus.o_ready, 0);
      check("bp_valid", bus.o_valid, 1);
      check("bp_mant",  bus.o_mant,  m_acc);
      check("bp_exp",   bus.o_exp,   m_exp);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    m_first     = 1'b1;
    drive_beat(55, 2, 3, 1);
    check("bp_next_const", bus.o_mant, 55);
    check_result("bp_next");

    for (int i = 0; i < 4; i++) drive_beat((64'sd1 <<< 23) - 1, 31, 31, (i == 3));
`ifdef GFP8_ACC_SATURATE_EN
    check("ovf_mant_const", bus.o_mant, (64'sd1 <<< 24) - 1);
    check("ovf_sat_const",  bus.o_sat,  1);
`else
    check("ovf_sat_const",  bus.o_sat,  0);
`endif
    check_result("ovf");

    drive_beat(1000, 5, 5, 0);
    drive_beat(-7, 2, 2, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_count", bus.o_count, 0);
    check("midrst_mant",  bus.o_mant,  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_first = 1'b1;
    drive_beat(42, 1, 1, 0);
    drive_beat(8, 1, 2, 1);
    check("post_rst_const", bus.o_mant, 29);
    check_result("post_rst");

    for (int i = 0; i < 300; i++) drive_beat(1, 0, 0, (i == 299));
    check("cnt_sat_const", bus.o_count, 255);
    check_result("cnt_sat");

    for (int el = 0; el < 25; el++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        rdot = DOT_W'($urandom);
        drive_beat(longint'(rdot), $urandom_range(0, 31), $urandom_range(0, 31), (b == len - 1));
      end
      check_result("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
